aim_stream_matcher: RTL and testbench
=====================================

// Module: aim_stream_matcher
// PURPOSE
//   Parametrised associative index matcher: N_LANES weight-channel keys are searched against a stream of
//   input-activation (IA) chunks; per lane, reports the global position of the first IA element equal to its key.
//   Sits between the IA buffer (chunk producer) and the sparse-MAC scheduler (consumes o_valid/o_pos on o_done).
//   Adds over the previous generation: chunk valid/ready handshake, deterministic lowest-index priority encoding,
//   first-match retention across chunks, busy/done status and results held stable until the next run.
// PARAMETERS
//   N_LANES    32  number of keys / result lanes
//   KEY_W      16  key width
//   DATA_W     6   IA element width (DATA_W <= KEY_W; element zero-extended to KEY_W before compare)
//   CHUNK      32  IA elements per chunk (power of two)
//   MAX_CHUNKS 8   max chunks per run (power of two); CNT_W = clog2(MAX_CHUNKS), POS_W = clog2(CHUNK*MAX_CHUNKS)
// PORTS
//   i_clk          in   1                clock, all state on rising edge
//   i_rst_n        in   1                asynchronous active-low reset
//   i_start        in   1                start run; sampled only in S_IDLE
//   i_last_chunk   in   CNT_W            number of chunks in run minus 1; latched on accepted i_start
//   i_key          in   N_LANES*KEY_W    lane k key at [k*KEY_W +: KEY_W]; latched on accepted i_start
//   i_chunk_valid  in   1                chunk data valid
//   i_chunk        in   CHUNK*DATA_W     element e at [e*DATA_W +: DATA_W]
//   o_chunk_ready  out  1                matcher accepts chunk this cycle
//   o_busy         out  1                high in every state except S_IDLE
//   o_done         out  1                one-cycle pulse: results final
//   o_valid        out  N_LANES          lane k found a match
//   o_pos          out  N_LANES*POS_W    lane k position = chunk_idx*CHUNK + element index; 0 when !o_valid[k]
//   o_multi        out  N_LANES          lane k matched more than once in the run (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: state S_IDLE, chunk counter 0, latched keys 0, o_chunk_ready/o_busy/o_done 0, o_valid/o_pos/o_multi 0.
//   - All outputs registered; no X/Z ever driven (unmatched lanes encode to valid 0, pos 0).
//   - FSM: S_IDLE -i_start-> S_WAIT; S_WAIT -(valid&ready)-> S_COMP -> S_ENCO;
//     S_ENCO -> S_DONE if chunk_idx == last_chunk, else S_WAIT with chunk_idx+1; S_DONE -> S_IDLE.
//   - Accepted i_start: latch keys/last_chunk, clear o_valid/o_pos/o_multi and chunk_idx next cycle.
//   - S_WAIT: o_chunk_ready=1; chunk registered on valid&ready. Stall indefinitely while !i_chunk_valid.
//   - S_COMP: register match map[k][e] = (zext(chunk[e]) == key[k]); o_chunk_ready=0.
//   - S_ENCO: per lane, lowest set e of map[k] is the hit; if lane not yet valid and hit exists:
//     o_valid[k]<=1, o_pos[k]<=chunk_idx*CHUNK+e. Lanes already valid keep their position (first match wins).
//   - Chunk throughput: 1 chunk / 3 cycles; results for chunk visible 2 cycles after acceptance.
//   - S_DONE: o_done=1 exactly one cycle; results then held unchanged until next accepted i_start.
//   - i_start outside S_IDLE ignored; i_chunk_valid outside S_WAIT ignored (not consumed).
//   - i_last_chunk=0: single-chunk run. Max run: i_last_chunk=MAX_CHUNKS-1, pos wraps never (POS_W sized).
//   - Async reset mid-run: all state/outputs to reset values immediately; partial results discarded.
// CONFIGURATION
//   AIM_MULTI_HIT_EN defined: o_multi[k] set when map[k] has >=2 bits in one chunk, or lane already valid
//     and a further hit occurs in a later chunk; cleared on accepted i_start.
//   Not defined: o_multi port present, tied to 0; no popcount/compare logic synthesised.
// TESTING
//   1 Defaults, keys k=lane k, one chunk elems e=e, last_chunk=0 -> o_done 4 cycles after chunk accept,
//     all lanes valid, o_pos[k]=k.
//   2 Key[3]=9, chunk0 no 9, chunk2 elem 5=9, last_chunk=3 -> o_valid[3]=1, o_pos[3]=69; lanes with no hit valid 0 pos 0.
//   3 Key[0]=7, chunk0 elems 4 and 20 =7, chunk1 elem 1=7 -> o_pos[0]=4; o_multi[0]=1 with AIM_MULTI_HIT_EN, 0 without.
//   4 Hold i_chunk_valid low 10 cycles in S_WAIT, pulse i_start while busy -> ready held, start ignored, results unchanged.
//   5 Assert i_rst_n low during S_COMP of chunk 1 -> all outputs 0 next edge; new run afterwards gives correct results.
//   6 Key=0x0040 with DATA_W=6 elements all 0x00..0x3F -> no lane match (zero-extend), o_valid=0 after o_done.

Source files
------------

// File: rtl/aim_stream_matcher.sv
`default_nettype none
// ============================================================================
//  Module      : aim_stream_matcher
//  Description : Associative index matcher. N_LANES latched keys are compared
//                against a stream of IA chunks; each lane reports the global
//                position of the first IA element equal to its key.
//                Optional feature macro: AIM_MULTI_HIT_EN (enables o_multi).
//  Revision    : 1.0 - initial release
// ============================================================================
module aim_stream_matcher #(
   parameter  int N_LANES    = 32,
   parameter  int KEY_W      = 16,
   parameter  int DATA_W     = 6,
   parameter  int CHUNK      = 32,
   parameter  int MAX_CHUNKS = 8,
   localparam int CNT_W      = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1,
   localparam int POS_W      = $clog2(CHUNK * MAX_CHUNKS)
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_start,
   input  logic [CNT_W-1:0]           i_last_chunk,
   input  logic [N_LANES*KEY_W-1:0]   i_key,
   input  logic                       i_chunk_valid,
   input  logic [CHUNK*DATA_W-1:0]    i_chunk,
   output logic                       o_chunk_ready,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [N_LANES-1:0]         o_valid,
   output logic [N_LANES*POS_W-1:0]   o_pos,
   output logic [N_LANES-1:0]         o_multi
);

   localparam int c_eidx_w = (CHUNK > 1) ? $clog2(CHUNK) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_COMP = 3'd2,
      S_ENCO = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                    r_state;
   logic [CNT_W-1:0]          r_chunk_idx;
   logic [CNT_W-1:0]          r_last_chunk;
   logic [N_LANES*KEY_W-1:0]  r_key;
   logic [CHUNK*DATA_W-1:0]   r_chunk;
   logic [CHUNK-1:0]          r_map [N_LANES];

   logic [CHUNK-1:0]          w_map  [N_LANES];
   logic [N_LANES-1:0]        w_hit;
   logic [c_eidx_w-1:0]       w_eidx [N_LANES];
   logic [POS_W-1:0]          w_pos  [N_LANES];

   // Match map of the registered chunk: element zero-extended, compared to every key
   always_comb begin
      for (int k = 0; k < N_LANES; k++) begin
         w_map[k] = '0;
         for (int e = 0; e < CHUNK; e++) begin
            w_map[k][e] = (KEY_W'(r_chunk[e*DATA_W +: DATA_W]) == r_key[k*KEY_W +: KEY_W]);
         end
      end
   end

   // Lowest-index priority encoder per lane; scanning downward lets the lowest hit win
   always_comb begin
      for (int k = 0; k < N_LANES; k++) begin
         w_hit[k]  = |r_map[k];
         w_eidx[k] = '0;
         for (int e = CHUNK - 1; e >= 0; e--) begin
            if (r_map[k][e]) begin
               w_eidx[k] = c_eidx_w'(e);
            end
         end
         w_pos[k] = (POS_W'(r_chunk_idx) << c_eidx_w) | POS_W'(w_eidx[k]);
      end
   end

`ifdef AIM_MULTI_HIT_EN
   logic [N_LANES-1:0] w_multi;

   // Repeat hit: two or more bits in this chunk, or a new hit on an already-matched lane
   always_comb begin
      for (int k = 0; k < N_LANES; k++) begin
         w_multi[k] = ((r_map[k] & (r_map[k] - 1'b1)) != '0) || (o_valid[k] && w_hit[k]);
      end
   end
`else
   assign o_multi = '0;
`endif

   // Control FSM with registered status, result and datapath registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_chunk_idx   <= '0;
         r_last_chunk  <= '0;
         r_key         <= '0;
         r_chunk       <= '0;
         for (int k = 0; k < N_LANES; k++) begin
            r_map[k] <= '0;
         end
         o_chunk_ready <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_valid       <= '0;
         o_pos         <= '0;
`ifdef AIM_MULTI_HIT_EN
         o_multi       <= '0;
`endif
      end else begin
         o_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_key         <= i_key;
                  r_last_chunk  <= i_last_chunk;
                  r_chunk_idx   <= '0;
                  o_valid       <= '0;
                  o_pos         <= '0;
`ifdef AIM_MULTI_HIT_EN
                  o_multi       <= '0;
`endif
                  o_busy        <= 1'b1;
                  o_chunk_ready <= 1'b1;
                  r_state       <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_chunk_valid && o_chunk_ready) begin
                  r_chunk       <= i_chunk;
                  o_chunk_ready <= 1'b0;
                  r_state       <= S_COMP;
               end
            end
            S_COMP: begin
               for (int k = 0; k < N_LANES; k++) begin
                  r_map[k] <= w_map[k];
               end
               r_state <= S_ENCO;
            end
            S_ENCO: begin
               for (int k = 0; k < N_LANES; k++) begin
                  if (!o_valid[k] && w_hit[k]) begin
                     o_valid[k]               <= 1'b1;
                     o_pos[k*POS_W +: POS_W]  <= w_pos[k];
                  end
`ifdef AIM_MULTI_HIT_EN
                  if (w_multi[k]) begin
                     o_multi[k] <= 1'b1;
                  end
`endif
               end
               if (r_chunk_idx == r_last_chunk) begin
                  r_state <= S_DONE;
               end else begin
                  r_chunk_idx   <= r_chunk_idx + 1'b1;
                  o_chunk_ready <= 1'b1;
                  r_state       <= S_WAIT;
               end
            end
            S_DONE: begin
               o_done  <= 1'b1;
               o_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               o_busy        <= 1'b0;
               o_chunk_ready <= 1'b0;
               r_state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aim_stream_matcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aim_stream_matcher
//  Description : Self-checking bench for aim_stream_matcher. Expected results
//                come from a position-scan model over the whole run.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aim_stream_matcher;

   localparam int N_LANES    = 32;
   localparam int KEY_W      = 16;
   localparam int DATA_W     = 6;
   localparam int CHUNK      = 32;
   localparam int MAX_CHUNKS = 8;
   localparam int CNT_W      = 3;
   localparam int POS_W      = 8;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic                       start;
   logic [CNT_W-1:0]           last_chunk;
   logic [N_LANES*KEY_W-1:0]   key;
   logic                       chunk_valid;
   logic [CHUNK*DATA_W-1:0]    chunk;
   logic                       chunk_ready;
   logic                       busy;
   logic                       done;
   logic [N_LANES-1:0]         valid;
   logic [N_LANES*POS_W-1:0]   pos;
   logic [N_LANES-1:0]         multi;

   int total = 0;
   int bad   = 0;

   // Stimulus for the current run and the model's expectations
   logic [KEY_W-1:0]           keys  [N_LANES];
   logic [DATA_W-1:0]          elems [MAX_CHUNKS][CHUNK];
   int                         n_chunks;
   logic [N_LANES-1:0]         exp_valid;
   logic [N_LANES*POS_W-1:0]   exp_pos;
   logic [N_LANES-1:0]         exp_multi;

   aim_stream_matcher #(
      .N_LANES(N_LANES), .KEY_W(KEY_W), .DATA_W(DATA_W),
      .CHUNK(CHUNK), .MAX_CHUNKS(MAX_CHUNKS)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_last_chunk(last_chunk),
      .i_key(key), .i_chunk_valid(chunk_valid), .i_chunk(chunk),
      .o_chunk_ready(chunk_ready), .o_busy(busy), .o_done(done),
      .o_valid(valid), .o_pos(pos), .o_multi(multi)
   );

   always #5 clk = ~clk;

   // Scan every global position of the run in order; first hit is the position, hit count >= 2 is multi
   function automatic void model_compute();
      int first, cnt;
      exp_valid = '0;
      exp_pos   = '0;
      exp_multi = '0;
      for (int k = 0; k < N_LANES; k++) begin
         cnt   = 0;
         first = 0;
         for (int p = 0; p < n_chunks * CHUNK; p++) begin
            if (int'(elems[p / CHUNK][p % CHUNK]) == int'(keys[k])) begin
               if (cnt == 0) first = p;
               cnt++;
            end
         end
         if (cnt > 0) begin
            exp_valid[k]                = 1'b1;
            exp_pos[k*POS_W +: POS_W]   = POS_W'(first);
         end
`ifdef AIM_MULTI_HIT_EN
         exp_multi[k] = (cnt >= 2);
`endif
      end
   endfunction

   function automatic void random_stimulus(input int n);
      n_chunks = n;
      for (int k = 0; k < N_LANES; k++)
         keys[k] = $urandom_range(0, 1) ? KEY_W'($urandom_range(0, 63)) : KEY_W'($urandom_range(64, 65535));
      for (int c = 0; c < MAX_CHUNKS; c++)
         for (int e = 0; e < CHUNK; e++)
            elems[c][e] = DATA_W'($urandom_range(0, 63));
   endfunction

   // Drive one run; returns at the negedge where o_done is seen (or after chunk abort_after is accepted)
   task automatic do_run(input int gap_max, input bit immediate, input int abort_after,
                         output bit ok, output int lat);
      int cnt;
      ok  = 1'b1;
      lat = 0;
      if (!immediate) @(negedge clk);
      start      = 1'b1;
      last_chunk = CNT_W'(n_chunks - 1);
      for (int k = 0; k < N_LANES; k++) key[k*KEY_W +: KEY_W] = keys[k];
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < N_LANES; k++) key[k*KEY_W +: KEY_W] = KEY_W'($urandom);
      for (int c = 0; c < n_chunks; c++) begin
         if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
         chunk_valid = 1'b1;
         for (int e = 0; e < CHUNK; e++) chunk[e*DATA_W +: DATA_W] = elems[c][e];
         cnt = 0;
         while (chunk_ready !== 1'b1 && cnt < 64) begin
            @(negedge clk);
            cnt++;
         end
         if (chunk_ready !== 1'b1) begin
            ok = 1'b0;
            chunk_valid = 1'b0;
            return;
         end
         @(negedge clk);
         chunk_valid = 1'b0;
         for (int e = 0; e < CHUNK; e++) chunk[e*DATA_W +: DATA_W] = DATA_W'($urandom);
         if (c == abort_after) return;
      end
      lat = 1;
      while (done !== 1'b1 && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) ok = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; last_chunk = '0; key = '0; chunk_valid = 1'b0; chunk = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({chunk_ready, busy, done, valid, pos, multi} !== '0)
         $display("FAIL reset_outputs got rdy=%b busy=%b done=%b valid=%h pos=%h multi=%h want all 0",
                  chunk_ready, busy, done, valid, pos, multi);
      if ({chunk_ready, busy, done, valid, pos, multi} !== '0) bad++;
      @(negedge clk);
      rst_n = 1'b1;
      chunk_valid = 1'b1;
      repeat (2) @(negedge clk);
      chunk_valid = 1'b0;
      total++;
      if ({chunk_ready, busy, done, valid} !== '0) begin
         bad++;
         $display("FAIL idle_after_reset got rdy=%b busy=%b done=%b valid=%h want 0", chunk_ready, busy, done, valid);
      end
   endtask

   task automatic test_identity();
      bit ok; int lat;
      n_chunks = 1;
      for (int k = 0; k < N_LANES; k++) keys[k] = KEY_W'(k);
      for (int e = 0; e < CHUNK; e++) elems[0][e] = DATA_W'(e);
      do_run(0, 1'b0, -1, ok, lat);
      model_compute();
      total++;
      if (!ok || lat != 4) begin bad++; $display("FAIL identity_done_latency got ok=%0d lat=%0d want ok=1 lat=4", ok, lat); end
      total++;
      if (valid !== {N_LANES{1'b1}}) begin bad++; $display("FAIL identity_valid got %h want all ones", valid); end
      total++;
      if (pos !== exp_pos) begin bad++; $display("FAIL identity_pos got %h want %h", pos, exp_pos); end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL done_one_cycle got done=%b busy=%b want 0 0", done, busy); end
   endtask

   task automatic test_late_hit();
      bit ok; int lat;
      logic [POS_W-1:0] p3;
      n_chunks = 4;
      for (int k = 0; k < N_LANES; k++) keys[k] = KEY_W'(16'h1000 + k);
      keys[3] = 16'd9;
      for (int c = 0; c < MAX_CHUNKS; c++)
         for (int e = 0; e < CHUNK; e++) begin
            elems[c][e] = DATA_W'($urandom_range(0, 63));
            if (elems[c][e] == 6'd9) elems[c][e] = 6'd10;
         end
      elems[2][5] = 6'd9;
      do_run(2, 1'b0, -1, ok, lat);
      model_compute();
      p3 = pos[3*POS_W +: POS_W];
      total++;
      if (!ok || valid !== exp_valid) begin bad++; $display("FAIL late_hit_valid got ok=%0d valid=%h want %h", ok, valid, exp_valid); end
      total++;
      if (p3 !== 8'd69 || pos !== exp_pos) begin bad++; $display("FAIL late_hit_pos got pos3=%0d pos=%h want 69 %h", p3, pos, exp_pos); end
   endtask

   task automatic test_first_match();
      bit ok; int lat;
      logic [POS_W-1:0] p0;
      n_chunks = 2;
      for (int k = 0; k < N_LANES; k++) keys[k] = KEY_W'(16'h2000 + k);
      keys[0] = 16'd7;
      for (int c = 0; c < MAX_CHUNKS; c++)
         for (int e = 0; e < CHUNK; e++) begin
            elems[c][e] = DATA_W'($urandom_range(0, 63));
            if (elems[c][e] == 6'd7) elems[c][e] = 6'd8;
         end
      elems[0][4] = 6'd7; elems[0][20] = 6'd7; elems[1][1] = 6'd7;
      do_run(1, 1'b0, -1, ok, lat);
      model_compute();
      p0 = pos[POS_W-1:0];
      total++;
      if (!ok || valid !== exp_valid || p0 !== 8'd4) begin
         bad++; $display("FAIL first_match got ok=%0d valid=%h pos0=%0d want %h 4", ok, valid, p0, exp_valid);
      end
      total++;
      if (multi !== exp_multi) begin bad++; $display("FAIL first_match_multi got %h want %h", multi, exp_multi); end
   endtask

   task automatic test_stall_and_ignore();
      bit rdy_ok, idle_ok; int cnt;
      logic [N_LANES-1:0] v_hold;
      random_stimulus(1);
      @(negedge clk);
      start = 1'b1; last_chunk = '0;
      for (int k = 0; k < N_LANES; k++) key[k*KEY_W +: KEY_W] = keys[k];
      @(negedge clk);
      start  = 1'b0;
      rdy_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (chunk_ready !== 1'b1 || busy !== 1'b1) rdy_ok = 1'b0;
         start = (i == 4);
         if (i == 4) begin
            last_chunk = '1;
            for (int k = 0; k < N_LANES; k++) key[k*KEY_W +: KEY_W] = ~keys[k];
         end
         @(negedge clk);
      end
      start = 1'b0;
      total++;
      if (!rdy_ok) begin bad++; $display("FAIL stall_ready got ready/busy dropped want held 1"); end
      chunk_valid = 1'b1;
      for (int e = 0; e < CHUNK; e++) chunk[e*DATA_W +: DATA_W] = elems[0][e];
      @(negedge clk);
      chunk_valid = 1'b0;
      cnt = 1;
      while (done !== 1'b1 && cnt < 64) begin @(negedge clk); cnt++; end
      model_compute();
      total++;
      if (cnt != 4) begin bad++; $display("FAIL stall_done_latency got %0d want 4", cnt); end
      total++;
      if (valid !== exp_valid || pos !== exp_pos) begin
         bad++; $display("FAIL stall_results got valid=%h pos=%h want %h %h", valid, pos, exp_valid, exp_pos);
      end
      // Chunks offered while idle must not be consumed nor disturb the held results
      v_hold  = exp_valid;
      idle_ok = 1'b1;
      chunk_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         for (int e = 0; e < CHUNK; e++) chunk[e*DATA_W +: DATA_W] = DATA_W'($urandom);
         @(negedge clk);
         if (chunk_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0) idle_ok = 1'b0;
      end
      chunk_valid = 1'b0;
      total++;
      if (!idle_ok || valid !== v_hold || pos !== exp_pos || multi !== exp_multi) begin
         bad++; $display("FAIL idle_hold got idle_ok=%0d valid=%h pos=%h want %h %h", idle_ok, valid, pos, v_hold, exp_pos);
      end
   endtask

   task automatic test_reset_mid_run();
      bit ok; int lat;
      random_stimulus(3);
      do_run(0, 1'b0, 1, ok, lat);
      rst_n = 1'b0;
      #1;
      total++;
      if (!ok || {chunk_ready, busy, done, valid, pos, multi} !== '0) begin
         bad++; $display("FAIL reset_mid_run got ok=%0d busy=%b valid=%h pos=%h want all 0", ok, busy, valid, pos);
      end
      @(negedge clk);
      rst_n = 1'b1;
      random_stimulus(3);
      do_run(1, 1'b0, -1, ok, lat);
      model_compute();
      total++;
      if (!ok || valid !== exp_valid || pos !== exp_pos || multi !== exp_multi) begin
         bad++; $display("FAIL after_reset_run got ok=%0d valid=%h pos=%h multi=%h want %h %h %h",
                         ok, valid, pos, multi, exp_valid, exp_pos, exp_multi);
      end
   endtask

   task automatic test_zero_extend();
      bit ok; int lat;
      n_chunks = 2;
      for (int k = 0; k < N_LANES; k++) keys[k] = 16'h0040;
      for (int e = 0; e < CHUNK; e++) begin
         elems[0][e] = DATA_W'(e);
         elems[1][e] = DATA_W'(CHUNK + e);
      end
      do_run(0, 1'b0, -1, ok, lat);
      total++;
      if (!ok || valid !== '0 || pos !== '0 || multi !== '0) begin
         bad++; $display("FAIL zero_extend got ok=%0d valid=%h pos=%h want 0 0", ok, valid, pos);
      end
   endtask

   task automatic test_random_back_to_back();
      bit ok; int lat;
      for (int i = 0; i < 16; i++) begin
         random_stimulus($urandom_range(1, MAX_CHUNKS));
         if (i == 15) n_chunks = MAX_CHUNKS;
         do_run($urandom_range(0, 3), (i > 0) && ($urandom_range(0, 1) == 1), -1, ok, lat);
         model_compute();
         total++;
         if (!ok || valid !== exp_valid || pos !== exp_pos || multi !== exp_multi) begin
            bad++; $display("FAIL random_run_%0d got ok=%0d valid=%h pos=%h multi=%h want %h %h %h",
                            i, ok, valid, pos, multi, exp_valid, exp_pos, exp_multi);
         end
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_late_hit();
      test_first_match();
      test_stall_and_ignore();
      test_reset_mid_run();
      test_zero_extend();
      test_random_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
